// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   WIDTH   : default operand/result width
//   CNT_W   : iteration counter width, wide enough to count 0..WIDTH
//   state_t : divider FSM state encoding
package div_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor for the restoring divider.
//   a      : minuend (shifted partial remainder), N bits
//   b      : subtrahend (zero-extended divisor magnitude), N bits
//   diff   : a - b, N bits
//   borrow : 1 when a < b (unsigned), i.e. the trial failed
module div_trial_sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  // One extra bit on the left catches the borrow out of the N-bit subtract.
  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end
endmodule

// File: rtl/div_32_seq.sv
// Sequential signed restoring divider (DIV: quotient -> LO, remainder -> HI).
// One trial subtraction per cycle on operand magnitudes, then a sign fixup.
//   clock, clear      : rising-edge clock, synchronous active-high reset
//   start             : begin a divide; only looked at while idle
//   Ra, Rb            : dividend / divisor, two's complement
//   busy              : operation in flight
//   done              : one-cycle completion pulse
//   quotient          : truncated-toward-zero quotient, held until next done
//   remainder         : remainder with the sign of the dividend
//   div_by_zero       : Rb was zero (quotient all ones, remainder = Ra)
module div_32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // |Rb|
  logic             neg_q_q, neg_q_d;  // quotient needs negation
  logic             neg_r_q, neg_r_d;  // remainder needs negation
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic             trial_ok;

  assign shifted = {rem_q, q_q[WIDTH-1]};

  div_trial_sub #(.N(WIDTH + 1)) u_trial (
    .a      (shifted),
    .b      ({1'b0, dvs_q}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // rem < divisor always holds, so a successful trial never sets the top
  // difference bit; folding it in is redundant but keeps every bit used.
  assign trial_ok = !trial_borrow && !trial_diff[WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Unsigned magnitudes make |-2^(W-1)| exact.
          q_d     = Ra[WIDTH-1] ? (~Ra + 1'b1) : Ra;
          dvs_d   = Rb[WIDTH-1] ? (~Rb + 1'b1) : Rb;
          neg_q_d = Ra[WIDTH-1] ^ Rb[WIDTH-1];
          neg_r_d = Ra[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          if (Rb != '0) begin
            state_d = ITER;
            busy_d  = 1'b1;
          end else begin
            quo_d  = '1;
            res_d  = Ra;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ITER: begin
        rem_d = trial_ok ? trial_diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], trial_ok};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        quo_d   = neg_q_q ? (~q_q + 1'b1) : q_q;
        res_d   = neg_r_q ? (~rem_q + 1'b1) : rem_q;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = res_q;
  assign div_by_zero = dbz_q;
endmodule
